// File: rtl/exec_controller.sv
// rtl/exec_controller.sv - single-step / free-run execution controller with breakpoint
//
// Purpose: turns two raw push buttons into processor step enables. A step
// button issues one instruction; a run button toggles free-running mode,
// where one instruction is issued every RUN_DIV clocks until the run button
// is pressed again or the PC hits the breakpoint address.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high
//   btn_step   - raw single-step button (asynchronous, bouncy)
//   btn_run    - raw run/halt toggle button (asynchronous, bouncy)
//   bp_en      - breakpoint enable
//   bp_addr    - breakpoint PC value
//   pc         - current processor PC
//   step_en    - one-clock pulse advancing the processor one instruction
//   running    - high while free-running
//   halted_bp  - high while stopped at the breakpoint
//   step_count - number of issued steps, wraps at 16 bits

module exec_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_step,
  input  logic        btn_run,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        step_en,
  output logic        running,
  output logic        halted_bp,
  output logic [15:0] step_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(RUN_DIV);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LOAD = TW'(RUN_DIV - 1);

  typedef enum logic [1:0] {IDLE, STEP, RUN, BREAK} state_t;

  state_t state, state_nxt;

  // Button index 0 = step, 1 = run.
  logic [1:0]    btn_raw;
  logic [1:0]    sync_a, sync_b;
  logic [1:0]    deb_level;
  logic [1:0]    press;
  logic [1:0]    armed;
  logic [CW-1:0] deb_cnt [2];
  logic [1:0]    settle_cnt;
  logic          settled;

  logic          run_press, step_press;
  logic [TW-1:0] tick, tick_nxt;
  logic          resume, resume_nxt;
  logic          step_nxt;

  assign btn_raw = {btn_run, btn_step};

  // The synchronizer output only reflects the real button two clocks after
  // reset releases; before that it still shows the reset value of 0.
  assign settled = (settle_cnt == 2'd2);

  // A button held through reset must be released before it can press:
  // armed only sets once the settled input and the debounced level are both
  // low, and a debounced rise while unarmed produces no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a     <= 2'b00;
      sync_b     <= 2'b00;
      deb_level  <= 2'b00;
      press      <= 2'b00;
      armed      <= 2'b00;
      settle_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      if (!settled) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (settled && !sync_b[i] && !deb_level[i]) begin
          armed[i] <= 1'b1;
        end
        if (sync_b[i] != deb_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_level[i] <= sync_b[i];
            deb_cnt[i]   <= '0;
            press[i]     <= sync_b[i] & armed[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Run wins over a simultaneous step press.
  assign run_press  = press[1];
  assign step_press = press[0] & ~press[1];

  // step_en, running and halted_bp are registered from the next-state
  // decision so they line up with the state they describe.
  always_comb begin
    state_nxt  = state;
    step_nxt   = 1'b0;
    tick_nxt   = tick;
    resume_nxt = resume;
    case (state)
      IDLE: begin
        if (run_press) begin
          state_nxt  = RUN;
          tick_nxt   = TICK_LOAD;
          resume_nxt = 1'b0;
        end else if (step_press) begin
          state_nxt = STEP;
          step_nxt  = 1'b1;
        end
      end
      STEP: begin
        state_nxt = IDLE;
      end
      RUN: begin
        if (run_press) begin
          state_nxt  = IDLE;
          resume_nxt = 1'b0;
        end else if (tick == '0) begin
          // Resume only shields the first tick after leaving BREAK.
          resume_nxt = 1'b0;
          if (bp_en && (pc == bp_addr) && !resume) begin
            state_nxt = BREAK;
          end else begin
            step_nxt = 1'b1;
            tick_nxt = TICK_LOAD;
          end
        end else begin
          tick_nxt = tick - 1'b1;
        end
      end
      BREAK: begin
        if (run_press) begin
          state_nxt  = RUN;
          tick_nxt   = TICK_LOAD;
          resume_nxt = 1'b1;
        end else if (step_press) begin
          state_nxt = STEP;
          step_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step_en    <= 1'b0;
      running    <= 1'b0;
      halted_bp  <= 1'b0;
      resume     <= 1'b0;
      tick       <= '0;
      step_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      step_en   <= step_nxt;
      running   <= (state_nxt == RUN);
      halted_bp <= (state_nxt == BREAK);
      resume    <= resume_nxt;
      tick      <= tick_nxt;
      if (step_en) begin
        step_count <= step_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// tb/tb_exec_controller.sv - randomized self-checking bench for exec_controller

module tb_exec_controller;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_run = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        step_en;
  logic        running;
  logic        halted_bp;
  logic [15:0] step_count;

  int tests = 0;
  int fails = 0;

  // Behavioural observation state: the processor model advances pc by 4 per
  // step, and every RUN session must step at cycles 9, 17, 25 ... after entry.
  int          steps_seen = 0;
  int          run_cyc = 0;
  int          run_last = 0;
  int          exp_count = 0;
  bit          prev_se = 1'b0;
  bit          double_seen = 1'b0;
  bit          tick_err = 1'b0;
  logic [31:0] pc_model = 32'd0;

  always #5 clk = ~clk;

  exec_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .step_en(step_en),
    .running(running), .halted_bp(halted_bp), .step_count(step_count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  task automatic clk1();
    @(negedge clk);
    if (step_en) begin
      steps_seen++;
      pc_model = pc_model + 32'd4;
      if (prev_se) double_seen = 1'b1;
    end
    prev_se = step_en;
    if (running) begin
      run_cyc++;
      run_last = run_cyc;
      if (step_en !== ((run_cyc > 1) && ((run_cyc - 1) % DIV == 0))) tick_err = 1'b1;
    end else begin
      run_cyc = 0;
    end
    pc = pc_model;
  endtask

  task automatic clkn(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic hold(input bit s, input bit r, input int hi, input int lo);
    btn_step = s;
    btn_run = r;
    clkn(hi);
    btn_step = 1'b0;
    btn_run = 1'b0;
    clkn(lo);
  endtask

  task automatic do_reset();
    pc_model = 32'd0;
    pc = 32'd0;
    reset = 1'b1;
    clkn(3);
    reset = 1'b0;
    exp_count = 0;
    clkn(4);
  endtask

  // which: 0 = running, 1 = halted_bp
  task automatic wait_sig(input int which, input bit lvl, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      clk1();
      if (((which == 0) ? running : halted_bp) == lvl) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clkn(3);
    tests++; if (step_en !== 1'b0) begin fails++; $display("FAIL reset_step_en: got %b want 0", step_en); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", running); end
    tests++; if (halted_bp !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted_bp); end
    tests++; if (step_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", step_count); end
    reset = 1'b0;
    clkn(4);
  endtask

  task automatic test_single_step();
    int s0;
    s0 = steps_seen;
    hold(1'b1, 1'b0, 20, 12);
    exp_count++;
    tests++; if (steps_seen - s0 != 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", steps_seen - s0); end
    tests++; if (step_count !== 16'(exp_count)) begin fails++; $display("FAIL single_count: got %0d want %0d", step_count, exp_count); end
    tests++; if (running !== 1'b0 || halted_bp !== 1'b0) begin fails++; $display("FAIL single_idle: running=%b halted=%b want 0 0", running, halted_bp); end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = steps_seen;
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      clkn(2);
    end
    btn_step = 1'b0;
    clkn(12);
    tests++; if (steps_seen - s0 != 0) begin fails++; $display("FAIL bounce_pulses: got %0d want 0", steps_seen - s0); end
    tests++; if (step_count !== 16'(exp_count)) begin fails++; $display("FAIL bounce_count: got %0d want %0d", step_count, exp_count); end
  endtask

  task automatic test_held_through_reset();
    int s0;
    btn_step = 1'b1;
    pc_model = 32'd0;
    reset = 1'b1;
    clkn(3);
    reset = 1'b0;
    exp_count = 0;
    s0 = steps_seen;
    clkn(20);
    tests++; if (steps_seen - s0 != 0) begin fails++; $display("FAIL held_reset_pulses: got %0d want 0", steps_seen - s0); end
    btn_step = 1'b0;
    clkn(12);
    hold(1'b1, 1'b0, 10, 12);
    exp_count++;
    tests++; if (steps_seen - s0 != 1) begin fails++; $display("FAIL held_reset_repress: got %0d want 1", steps_seen - s0); end
    tests++; if (step_count !== 16'(exp_count)) begin fails++; $display("FAIL held_reset_count: got %0d want %0d", step_count, exp_count); end
  endtask

  task automatic test_free_run(input int window);
    int s0, n;
    bit ok;
    do_reset();
    s0 = steps_seen;
    btn_run = 1'b1;
    wait_sig(0, 1'b1, 20, ok);
    btn_run = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL run_enter: running=%b want 1 within 20 clocks", running); end
    // A step press while running must be ignored.
    hold(1'b1, 1'b0, 8, 0);
    clkn(window);
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL run_still_running: got %b want 1", running); end
    tests++; if (steps_seen - s0 != (run_cyc - 1) / DIV) begin fails++; $display("FAIL run_pulses: got %0d want %0d", steps_seen - s0, (run_cyc - 1) / DIV); end
    btn_run = 1'b1;
    wait_sig(0, 1'b0, 20, ok);
    btn_run = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL run_exit: running=%b want 0 within 20 clocks", running); end
    clkn(30);
    n = (run_last - 1) / DIV;
    exp_count += n;
    tests++; if (steps_seen - s0 != n) begin fails++; $display("FAIL run_after_exit: got %0d steps want %0d", steps_seen - s0, n); end
    tests++; if (step_count !== 16'(exp_count)) begin fails++; $display("FAIL run_count: got %0d want %0d", step_count, exp_count); end
    tests++; if (tick_err !== 1'b0) begin fails++; $display("FAIL run_tick_spacing: got err=%b want 0", tick_err); end
  endtask

  task automatic test_breakpoint();
    int s0;
    bit ok;
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h0000_000C;
    hold(1'b0, 1'b1, 8, 0);
    wait_sig(1, 1'b1, 80, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_reach: halted=%b want 1 within 80 clocks", halted_bp); end
    tests++; if (step_count !== 16'd3 || pc_model !== 32'hC) begin fails++; $display("FAIL bp_count: got count=%0d pc=%h want 3 0000000c", step_count, pc_model); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL bp_running: got %b want 0", running); end
    // Step out of BREAK executes the breakpoint instruction.
    hold(1'b1, 1'b0, 10, 12);
    tests++; if (step_count !== 16'd4 || pc_model !== 32'h10 || halted_bp !== 1'b0) begin fails++; $display("FAIL bp_step: got count=%0d pc=%h halted=%b want 4 00000010 0", step_count, pc_model, halted_bp); end
    bp_addr = 32'h0000_0014;
    hold(1'b0, 1'b1, 8, 0);
    wait_sig(1, 1'b1, 80, ok);
    tests++; if (!ok || step_count !== 16'd5) begin fails++; $display("FAIL bp_second: got halted=%b count=%0d want 1 5", halted_bp, step_count); end
    // Resume steps past the breakpoint on the first tick.
    s0 = steps_seen;
    hold(1'b0, 1'b1, 8, 0);
    for (int i = 0; i < 30 && steps_seen == s0; i++) clk1();
    clk1();
    tests++; if (step_count !== 16'd6 || pc_model !== 32'h18 || running !== 1'b1) begin fails++; $display("FAIL bp_resume: got count=%0d pc=%h running=%b want 6 00000018 1", step_count, pc_model, running); end
    hold(1'b0, 1'b1, 8, 0);
    wait_sig(0, 1'b0, 20, ok);
    clkn(12);
    exp_count = 5 + (run_last - 1) / DIV;
    tests++; if (step_count !== 16'(exp_count) || halted_bp !== 1'b0) begin fails++; $display("FAIL bp_resume_exit: got count=%0d halted=%b want %0d 0", step_count, halted_bp, exp_count); end
    bp_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    int s0;
    bit ok;
    do_reset();
    s0 = steps_seen;
    btn_step = 1'b1;
    btn_run = 1'b1;
    wait_sig(0, 1'b1, 20, ok);
    btn_step = 1'b0;
    btn_run = 1'b0;
    tests++; if (!ok || steps_seen - s0 != 0) begin fails++; $display("FAIL simul_run: got running=%b steps=%0d want 1 0", running, steps_seen - s0); end
    clkn(20);
    hold(1'b0, 1'b1, 8, 0);
    wait_sig(0, 1'b0, 20, ok);
    clkn(12);
    tests++; if (step_count !== 16'((run_last - 1) / DIV)) begin fails++; $display("FAIL simul_count: got %0d want %0d", step_count, (run_last - 1) / DIV); end
  endtask

  task automatic test_random_steps();
    int s0, n;
    do_reset();
    s0 = steps_seen;
    n = $urandom_range(6, 10);
    for (int i = 0; i < n; i++) begin
      // The breakpoint matches the current pc but is never checked outside RUN.
      bp_en = 1'($urandom_range(0, 1));
      pc_model = $urandom & 32'hFFFF_FFFC;
      bp_addr = pc_model;
      hold(1'b1, 1'b0, $urandom_range(7, 14), $urandom_range(10, 16));
      exp_count++;
    end
    bp_en = 1'b0;
    tests++; if (steps_seen - s0 != n) begin fails++; $display("FAIL rand_pulses: got %0d want %0d", steps_seen - s0, n); end
    tests++; if (step_count !== 16'(exp_count)) begin fails++; $display("FAIL rand_count: got %0d want %0d", step_count, exp_count); end
    tests++; if (halted_bp !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL rand_idle: running=%b halted=%b want 0 0", running, halted_bp); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_reset();
    hold(1'b0, 1'b1, 8, 0);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      clk1();
      if (run_cyc == DIV) ok = 1'b1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL midrun_reach: run_cyc=%0d want %0d", run_cyc, DIV); end
    // The next edge would issue a tick; reset must suppress it.
    reset = 1'b1;
    clk1();
    tests++; if (step_en !== 1'b0 || running !== 1'b0 || halted_bp !== 1'b0 || step_count !== 16'd0) begin fails++; $display("FAIL midrun_reset: got step_en=%b running=%b halted=%b count=%0d want 0 0 0 0", step_en, running, halted_bp, step_count); end
    reset = 1'b0;
    clkn(4);
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_bounce();
    test_held_through_reset();
    test_free_run(40);
    test_free_run($urandom_range(20, 60));
    test_breakpoint();
    test_simultaneous();
    test_random_steps();
    test_reset_mid_run();
    tests++; if (double_seen !== 1'b0) begin fails++; $display("FAIL step_consecutive: got %b want 0", double_seen); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
